mem_arbiter: RTL and testbench

- Shares the single external SRAM bus between the CPU core and one DMA requester (video/serial).
- Sits between the control unit's memory strobes plus datapath address/data and the board memory pins.
- Freezes the CPU via `cpu_hold` while DMA owns the bus.
- Enforces a bounded DMA burst, a minimum CPU share, and idle turnaround cycles on every ownership change.

---
 rtl/ccpu_bus_pkg.sv | 22 ++
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/ccpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// ccpu_bus_pkg
// Shared definitions for the CPU/DMA memory bus:
//   - arb_state_t : arbiter state encoding (S_CPU, S_TO_DMA, S_DMA, S_TO_CPU)
//   - DEF_ADDR_W / DEF_DATA_W : default bus widths
//   - DEF_MAX_BURST / DEF_CPU_SLOTS : default arbitration limits
// ---------------------------------------------------------------------------
package ccpu_bus_pkg;

    typedef enum logic [1:0] {
        S_CPU    = 2'd0,
        S_TO_DMA = 2'd1,
        S_DMA    = 2'd2,
        S_TO_CPU = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_CPU_SLOTS = 2;

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one external SRAM bus between the CPU core and a single DMA
// requester. DMA bursts are bounded to MAX_BURST beats, the CPU is given
// at least CPU_SLOTS consecutive cycles between grants, and every
// ownership change inserts one idle turnaround cycle with both strobes high.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_addr/cpu_wdata            CPU address / store data
//   cpu_oe_n/cpu_we_n             CPU strobes (active-low)
//   cpu_lock                      CPU mid-instruction, bus may not be taken
//   cpu_hold                      freezes the CPU while it does not own the bus
//   cpu_rdata                     mem_rdata passthrough
//   dma_req/dma_we/dma_addr/dma_wdata   DMA beat request
//   dma_gnt                       DMA owns the bus this cycle
//   dma_rvalid/dma_rdata          registered read return (one cycle later)
//   mem_addr/mem_wdata/mem_oe_n/mem_we_n/mem_rdata   SRAM pins
// ---------------------------------------------------------------------------
module mem_arbiter
    import ccpu_bus_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int CPU_SLOTS = DEF_CPU_SLOTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_oe_n,
    input  logic              cpu_we_n,
    input  logic              cpu_lock,
    output logic              cpu_hold,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_oe_n,
    output logic              mem_we_n,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam int SLOT_W = $clog2(CPU_SLOTS + 1);

    arb_state_t        state_reg, state_next;
    logic [SLOT_W-1:0] slot_reg, slot_next;
    logic [BEAT_W-1:0] beat_reg, beat_next;
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              beat;

    // State, counters and registered read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_CPU;
            slot_reg   <= '0;
            beat_reg   <= '0;
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            slot_reg   <= slot_next;
            beat_reg   <= beat_next;
            rvalid_reg <= beat & ~dma_we;
            if (beat && !dma_we) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    // Next-state logic and bus mux.
    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        beat_next  = beat_reg;
        beat       = 1'b0;
        cpu_hold   = 1'b1;
        dma_gnt    = 1'b0;
        mem_addr   = cpu_addr;
        mem_wdata  = cpu_wdata;
        mem_oe_n   = 1'b1;
        mem_we_n   = 1'b1;

        case (state_reg)
            S_CPU: begin
                cpu_hold = 1'b0;
                mem_oe_n = cpu_oe_n;
                mem_we_n = cpu_we_n;
                if (int'(slot_reg) < CPU_SLOTS) begin
                    slot_next = slot_reg + 1'b1;
                end
                // The current cycle counts towards the CPU share, hence +1.
                if (dma_req && !cpu_lock && (int'(slot_reg) + 1 >= CPU_SLOTS)) begin
                    state_next = S_TO_DMA;
                end
            end
            S_TO_DMA: begin
                beat_next  = '0;
                state_next = S_DMA;
            end
            S_DMA: begin
                dma_gnt   = 1'b1;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                if (dma_req) begin
                    beat      = 1'b1;
                    mem_we_n  = ~dma_we;
                    mem_oe_n  = dma_we;
                    beat_next = beat_reg + 1'b1;
                    if (int'(beat_reg) + 1 >= MAX_BURST) begin
                        state_next = S_TO_CPU;
                    end
                end else begin
                    state_next = S_TO_CPU;
                end
            end
            S_TO_CPU: begin
                slot_next  = '0;
                state_next = S_CPU;
            end
            default: begin
                state_next = S_CPU;
            end
        endcase

        // Reset parks the bus immediately, before the registered state follows.
        if (rst) begin
            beat     = 1'b0;
            cpu_hold = 1'b0;
            dma_gnt  = 1'b0;
            mem_oe_n = 1'b1;
            mem_we_n = 1'b1;
        end
    end

    assign dma_rvalid = rvalid_reg;
    assign dma_rdata  = rdata_reg;
    assign cpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter. Each cycle the bench states the expected
// grant/hold; read-beat data it drives on mem_rdata is queued and compared
// against dma_rdata when the read return appears one cycle later.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_oe_n;
    logic        cpu_we_n;
    logic        cpu_lock;
    logic        cpu_hold;
    logic [7:0]  cpu_rdata;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_gnt;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_oe_n;
    logic        mem_we_n;
    logic [7:0]  mem_rdata;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic [7:0] rd_q[$];
    logic       prev_rd   = 1'b0;
    logic [7:0] last_rdata = 8'h00;
    int         cyc_no    = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_oe_n   (cpu_oe_n),
        .cpu_we_n   (cpu_we_n),
        .cpu_lock   (cpu_lock),
        .cpu_hold   (cpu_hold),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_oe_n   (mem_oe_n),
        .mem_we_n   (mem_we_n),
        .mem_rdata  (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL cyc%0d %s observed=%0h expected=%0h", cyc_no, tag, obs, exp);
        end
    endtask

    // One bus cycle: inputs were set by the caller after the previous edge;
    // outputs are sampled on the falling edge.
    task automatic cyc(input logic exp_gnt, input logic exp_hold);
        logic [7:0] exp_d;
        @(negedge clk);
        chk("dma_gnt", 32'(dma_gnt), 32'(exp_gnt));
        chk("cpu_hold", 32'(cpu_hold), 32'(exp_hold));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(mem_rdata));
        if (rst) begin
            chk("rst_oe_n", 32'(mem_oe_n), 32'd1);
            chk("rst_we_n", 32'(mem_we_n), 32'd1);
        end else if (!exp_hold) begin
            chk("cpu_oe_n", 32'(mem_oe_n), 32'(cpu_oe_n));
            chk("cpu_we_n", 32'(mem_we_n), 32'(cpu_we_n));
            chk("cpu_addr", 32'(mem_addr), 32'(cpu_addr));
        end else if (exp_gnt && dma_req) begin
            chk("dma_addr", 32'(mem_addr), 32'(dma_addr));
            chk("dma_we_n", 32'(mem_we_n), 32'(!dma_we));
            chk("dma_oe_n", 32'(mem_oe_n), 32'(dma_we));
            if (dma_we) chk("dma_wdata", 32'(mem_wdata), 32'(dma_wdata));
        end else begin
            chk("idle_oe_n", 32'(mem_oe_n), 32'd1);
            chk("idle_we_n", 32'(mem_we_n), 32'd1);
        end
        chk("dma_rvalid", 32'(dma_rvalid), 32'(prev_rd));
        if (prev_rd) begin
            if (rd_q.size() == 0) begin
                chk("rd_q_empty", 32'(rd_q.size()), 32'd1);
            end else begin
                exp_d = rd_q.pop_front();
                chk("dma_rdata", 32'(dma_rdata), 32'(exp_d));
                last_rdata = exp_d;
            end
        end else begin
            chk("rdata_hold", 32'(dma_rdata), 32'(last_rdata));
        end
        prev_rd = exp_gnt && dma_req && !dma_we && !rst;
        if (prev_rd) rd_q.push_back(mem_rdata);
        if (rst) begin
            prev_rd = 1'b0;
            rd_q.delete();
            last_rdata = 8'h00;
        end
        $display("cyc%0d rst=%0b req=%0b we=%0b lock=%0b gnt=%0b hold=%0b rvalid=%0b rdata=%02h",
                 cyc_no, rst, dma_req, dma_we, cpu_lock, dma_gnt, cpu_hold, dma_rvalid, dma_rdata);
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    logic exp_g1[12] = '{0,0,0,1,1,1,1,0,0,0,0,1};
    logic exp_h1[12] = '{0,0,1,1,1,1,1,1,0,0,1,1};

    initial begin
        rst = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 8'h11; cpu_oe_n = 1'b0; cpu_we_n = 1'b1;
        cpu_lock = 1'b0; dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h8000; dma_wdata = 8'h00;
        mem_rdata = 8'h00;
        @(posedge clk);
        #1;
        // Reset: two cycles with CPU read strobe low.
        cyc(0, 0);
        cyc(0, 0);

        // Full-length read bursts from reset release.
        rst = 1'b0; dma_req = 1'b1; dma_we = 1'b0;
        for (int i = 0; i < 12; i++) begin
            mem_rdata = 8'h40 + 8'(i);
            dma_addr  = 16'h8000 + 16'(i);
            cpu_addr  = 16'h0200 + 16'(i);
            cyc(exp_g1[i], exp_h1[i]);
        end
        dma_req = 1'b0;
        cyc(1, 1);   // granted, no beat, exit
        cyc(0, 1);   // turnaround
        cyc(0, 0);
        cyc(0, 0);

        // cpu_lock blocks the grant.
        cpu_lock = 1'b1; dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h1234; dma_wdata = 8'hA5;
        for (int i = 0; i < 10; i++) cyc(0, 0);
        cpu_lock = 1'b0;
        cyc(0, 0);
        cyc(0, 1);
        cyc(1, 1);   // write beat 0x1234 <- 0xA5
        dma_req = 1'b0;
        cyc(1, 1);
        cyc(0, 1);
        cyc(0, 0);
        cyc(0, 0);

        // Short read burst terminated by dma_req falling.
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'h2000;
        cyc(0, 0);
        cyc(0, 1);
        mem_rdata = 8'h3C;
        cyc(1, 1);
        mem_rdata = 8'h5A; dma_addr = 16'h2001;
        cyc(1, 1);
        dma_req = 1'b0; mem_rdata = 8'hEE;
        cyc(1, 1);
        cyc(0, 1);
        cyc(0, 0);
        cyc(0, 0);

        // Reset during the second beat abandons the burst.
        dma_req = 1'b1; dma_addr = 16'h3000;
        cyc(0, 0);
        cyc(0, 1);
        mem_rdata = 8'h77;
        cyc(1, 1);
        rst = 1'b1; mem_rdata = 8'h99;
        cyc(0, 0);
        rst = 1'b0; dma_req = 1'b0;
        cyc(0, 0);
        cyc(0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
